// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and types for the SHA-256 stream padder.
//   BLOCK_W    - width of one SHA-256 message block
//   WORD_W     - SHA-256 word width
//   LEN_W      - width of the message bit-length field
//   PAD_BYTE   - first padding byte appended after the message
//   LEN_OFFSET - byte offset of the length field inside the final block
//   pad_state_t - padder control states
package sha256_pkg;

    localparam int BLOCK_W    = 512;
    localparam int WORD_W     = 32;
    localparam int LEN_W      = 64;

    localparam logic [7:0] PAD_BYTE   = 8'h80;
    localparam int         LEN_OFFSET = 56;

    typedef enum logic [1:0] {
        LOAD,
        EMIT,
        EMIT2
    } pad_state_t;

endpackage

// File: rtl/sha_pad_tail.sv
// sha_pad_tail: combinational padding of the final (partial) block.
// Ports:
//   buffer    in  message bytes 0..n-1 packed big-endian, remaining bytes zero
//   n         in  number of message bytes in buffer (0..64)
//   len       in  total message length in bits (including the final byte)
//   blk0      out first padded block
//   blk1      out second (pad-only) block, valid when needs_two
//   needs_two out padding spills into a second block
module sha_pad_tail
    import sha256_pkg::*;
(
    input  logic [BLOCK_W-1:0] buffer,
    input  logic [6:0]         n,
    input  logic [LEN_W-1:0]   len,
    output logic [BLOCK_W-1:0] blk0,
    output logic [BLOCK_W-1:0] blk1,
    output logic               needs_two
);

    logic [BLOCK_W-1:0] pad_mark;
    logic [BLOCK_W-1:0] len_field;

    always_comb begin
        // For n = 64 the low six bits are zero, so the marker lands on byte 0,
        // which is exactly where the second block needs it.
        pad_mark  = {PAD_BYTE, {(BLOCK_W-8){1'b0}}} >> {n[5:0], 3'b000};
        len_field = {{(BLOCK_W-LEN_W){1'b0}}, len};
        blk0      = buffer;
        blk1      = '0;
        needs_two = 1'b0;
        if (n == 7'd64) begin
            blk1      = pad_mark | len_field;
            needs_two = 1'b1;
        end else if (n >= 7'(LEN_OFFSET)) begin
            blk0      = buffer | pad_mark;
            blk1      = len_field;
            needs_two = 1'b1;
        end else begin
            blk0      = buffer | pad_mark | len_field;
        end
    end

endmodule

// File: rtl/sha256_stream_padder.sv
// sha256_stream_padder: byte-serial SHA-256 message padder.
// Packs bytes big-endian into 512-bit blocks and appends 0x80, zeros and the
// 64-bit message bit length; emits padded blocks over valid/ready.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid/in_ready     byte input handshake
//   in_data               message byte (first byte = most significant)
//   in_last               final beat of the message
//   in_empty              with in_last on the first beat: zero-length message
//   blk_valid/blk_ready   block output handshake
//   blk_data              padded block, byte i at bits [511-8i -: 8]
//   blk_first/blk_last    first / final block of the message
//   blk_idx               (SHA_PAD_STATS_EN only) block index within message
// Optional feature macro: SHA_PAD_STATS_EN
module sha256_stream_padder #(
    parameter int BLOCK_W = 512,
    parameter int LEN_W   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    input  logic               in_empty,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_first,
    output logic               blk_last
`ifdef SHA_PAD_STATS_EN
    ,
    output logic [31:0]        blk_idx
`endif
);
    import sha256_pkg::*;

    pad_state_t         state, state_next;
    logic [6:0]         idx;
    logic [LEN_W-1:0]   len;
    logic [BLOCK_W-1:0] buffer;
    logic [BLOCK_W-1:0] second_blk;
    logic               two_pending;
    logic               first_pending;

    logic               accept;
    logic               empty_beat;
    logic [BLOCK_W-1:0] buf_wr;
    logic [BLOCK_W-1:0] tail_buf;
    logic [6:0]         n_wr;
    logic [LEN_W-1:0]   len_wr;
    logic [BLOCK_W-1:0] tail_blk0, tail_blk1;
    logic               tail_two;

    assign in_ready  = (state == LOAD) && !reset;
    assign blk_valid = (state != LOAD);
    assign accept    = in_valid && in_ready;

    // in_empty only counts on the very first beat of a message, with in_last.
    assign empty_beat = in_empty && in_last && (idx == 7'd0) && (len == '0);
    assign buf_wr     = buffer | ({in_data, {(BLOCK_W-8){1'b0}}} >> {idx[5:0], 3'b000});
    assign tail_buf   = empty_beat ? '0 : buf_wr;
    assign n_wr       = empty_beat ? 7'd0 : idx + 7'd1;
    assign len_wr     = empty_beat ? len : len + LEN_W'(8);

    sha_pad_tail u_tail (
        .buffer    (tail_buf),
        .n         (n_wr),
        .len       (len_wr),
        .blk0      (tail_blk0),
        .blk1      (tail_blk1),
        .needs_two (tail_two)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            LOAD:  if (accept && (in_last || n_wr == 7'd64)) state_next = EMIT;
            EMIT:  if (blk_ready) state_next = two_pending ? EMIT2 : LOAD;
            EMIT2: if (blk_ready) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            len           <= '0;
            buffer        <= '0;
            second_blk    <= '0;
            two_pending   <= 1'b0;
            first_pending <= 1'b1;
            blk_data      <= '0;
            blk_first     <= 1'b0;
            blk_last      <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        len <= len_wr;
                        if (in_last) begin
                            blk_data    <= tail_blk0;
                            second_blk  <= tail_blk1;
                            two_pending <= tail_two;
                            blk_last    <= !tail_two;
                            blk_first   <= first_pending;
                            idx         <= '0;
                            buffer      <= '0;
                        end else if (n_wr == 7'd64) begin
                            blk_data    <= buf_wr;
                            two_pending <= 1'b0;
                            blk_last    <= 1'b0;
                            blk_first   <= first_pending;
                            idx         <= '0;
                            buffer      <= '0;
                        end else begin
                            buffer      <= buf_wr;
                            idx         <= n_wr;
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        if (two_pending) begin
                            blk_data      <= second_blk;
                            blk_first     <= 1'b0;
                            blk_last      <= 1'b1;
                            two_pending   <= 1'b0;
                            first_pending <= 1'b0;
                        end else begin
                            first_pending <= blk_last;
                            if (blk_last) len <= '0;
                        end
                    end
                end
                EMIT2: begin
                    if (blk_ready) begin
                        len           <= '0;
                        first_pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHA_PAD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       blk_idx <= '0;
        else if (blk_valid && blk_ready) blk_idx <= blk_last ? '0 : blk_idx + 32'd1;
    end
`endif

endmodule

// File: tb/tb_sha256_stream_padder.sv
// tb_sha256_stream_padder: randomized self-checking bench for
// sha256_stream_padder against a byte-level FIPS 180-4 padding model.
// Optional feature macro: SHA_PAD_STATS_EN (checks blk_idx when defined).
module tb_sha256_stream_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_last, in_empty;
    logic [7:0]   in_data;
    logic         blk_valid, blk_ready, blk_first, blk_last;
    logic [511:0] blk_data;
`ifdef SHA_PAD_STATS_EN
    logic [31:0]  blk_idx;
`endif

    sha256_stream_padder #(.BLOCK_W(512), .LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
`ifdef SHA_PAD_STATS_EN
        ,
        .blk_idx   (blk_idx)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   msg[$];
    logic [511:0] exp_blk[$];
    logic [511:0] last_blk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reference: pad the whole message as a byte string, then cut into blocks.
    function automatic void build_model();
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        exp_blk.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*b+i];
            exp_blk.push_back(blk);
        end
    endfunction

    task automatic drive_msg(input bit gaps, input bit noise, input bit no_last);
        int guard;
        int nbeats;
        nbeats = (msg.size() == 0) ? 1 : msg.size();
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            if (gaps && ($urandom % 4 == 0)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            if (msg.size() == 0) begin
                in_data  = 8'($urandom);
                in_last  = 1'b1;
                in_empty = 1'b1;
            end else begin
                in_data  = msg[i];
                in_last  = !no_last && (i == nbeats - 1);
                in_empty = (noise && !(i == 0 && in_last)) ? 1'($urandom) : 1'b0;
            end
            guard = 0;
            while (!in_ready && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 2000) begin
                check("drive_timeout", 512'(in_ready), 512'(1));
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    // bp_mode: 0 always ready, 1 random ready, 2 hold 5 cycles per block
    task automatic collect(input int bp_mode);
        int           got, guard, hold_cnt, nblk;
        logic         held;
        logic [511:0] held_data;
        logic         held_first, held_last;
        got = 0; guard = 0; hold_cnt = 0; held = 1'b0;
        held_data = '0; held_first = 1'b0; held_last = 1'b0;
        nblk = exp_blk.size();
        while (got < nblk && guard < 5000) begin
            @(negedge clk);
            guard++;
            case (bp_mode)
                0:       blk_ready = 1'b1;
                1:       blk_ready = ($urandom % 3 != 0);
                default: blk_ready = (hold_cnt >= 5);
            endcase
            if (held && !blk_valid) check("valid_drop", 512'(blk_valid), 512'(1));
            if (blk_valid) begin
                check("in_ready_emit", 512'(in_ready), 512'(0));
                if (held) begin
                    check("hold_data", blk_data, held_data);
                    check("hold_first", 512'(blk_first), 512'(held_first));
                    check("hold_last", 512'(blk_last), 512'(held_last));
                end
                if (blk_ready) begin
                    check($sformatf("blk%0d_data", got), blk_data, exp_blk[got]);
                    check($sformatf("blk%0d_first", got), 512'(blk_first), 512'(got == 0));
                    check($sformatf("blk%0d_last", got), 512'(blk_last), 512'(got == nblk - 1));
`ifdef SHA_PAD_STATS_EN
                    check($sformatf("blk%0d_idx", got), 512'(blk_idx), 512'(got));
`endif
                    last_blk = blk_data;
                    got++;
                    held = 1'b0;
                    hold_cnt = 0;
                end else begin
                    held       = 1'b1;
                    held_data  = blk_data;
                    held_first = blk_first;
                    held_last  = blk_last;
                    hold_cnt++;
                end
            end
        end
        if (got < nblk) check("blk_timeout", 512'(got), 512'(nblk));
        @(negedge clk);
        blk_ready = 1'b0;
    endtask

    task automatic run_msg(input int bp_mode, input bit gaps, input bit noise);
        build_model();
        fork
            drive_msg(gaps, noise, 1'b0);
            collect(bp_mode);
        join
        repeat (3) @(negedge clk);
        check("no_extra_blk", 512'(blk_valid), 512'(0));
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    endtask

    logic [511:0] abc_blk;

    initial begin
        abc_blk   = {32'h61626380, 416'b0, 64'h18};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_empty  = 1'b0;
        blk_ready = 1'b0;
        last_blk  = '0;
        repeat (3) @(negedge clk);
        check("rst_blk_valid", 512'(blk_valid), 512'(0));
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_blk_data", blk_data, 512'(0));
        check("rst_first", 512'(blk_first), 512'(0));
        check("rst_last", 512'(blk_last), 512'(0));
`ifdef SHA_PAD_STATS_EN
        check("rst_blk_idx", 512'(blk_idx), 512'(0));
`endif
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 512'(in_ready), 512'(1));

        // "abc"
        set_abc();
        run_msg(0, 1'b0, 1'b0);
        check("abc_const", last_blk, abc_blk);

        // 55, 56 bytes of 0x00.. ; 64 and 65 bytes of 0xAA; zero length
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'(i));
        run_msg(0, 1'b0, 1'b0);
        msg.push_back(8'd55);
        run_msg(0, 1'b0, 1'b0);
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'hAA);
        run_msg(0, 1'b0, 1'b0);
        msg.push_back(8'hAA);
        run_msg(0, 1'b0, 1'b0);
        msg.delete();
        run_msg(0, 1'b0, 1'b0);

        // backpressure: every block held 5 cycles
        msg.delete();
        for (int i = 0; i < 60; i++) msg.push_back(8'($urandom));
        run_msg(2, 1'b0, 1'b0);

        // reset after 10 bytes, then "abc"
        msg.delete();
        for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
        drive_msg(1'b0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midrst_in_ready", 512'(in_ready), 512'(0));
        check("midrst_blk_valid", 512'(blk_valid), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        set_abc();
        run_msg(0, 1'b0, 1'b0);
        check("abc_after_rst", last_blk, abc_blk);

        // reset while a full block is waiting in EMIT
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
        drive_msg(1'b0, 1'b0, 1'b1);
        check("full_blk_pending", 512'(blk_valid), 512'(1));
        #2 reset = 1'b1;
        #1;
        check("emitrst_blk_valid", 512'(blk_valid), 512'(0));
        check("emitrst_blk_data", blk_data, 512'(0));
        @(negedge clk);
        reset = 1'b0;
        set_abc();
        run_msg(1, 1'b1, 1'b0);
        check("abc_after_emit_rst", last_blk, abc_blk);

        // random messages with random backpressure, gaps and ignored in_empty
        for (int t = 0; t < 25; t++) begin
            int len;
            len = $urandom_range(0, 140);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            run_msg(1, 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_stream_padder.md
Name: sha256_stream_padder

Overview:
- Byte-serial front end that feeds the SHA-256 compression core.
- Accepts an arbitrary-length message one byte per beat over valid/ready, packs the bytes big-endian into 512-bit blocks and appends FIPS 180-4 padding (0x80, zeros, 64-bit bit length).
- Emits complete padded blocks over a second valid/ready interface to the `sha256` core.
- Replaces the fixed-size combinational padder for variable-length messages.

Parameters:
- BLOCK_W, 512, width of an emitted block (fixed by SHA-256; not to be overridden).
- LEN_W, 64, width of the message bit-length counter and length field.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  message byte present.
- in_ready  output  1  padder can take a byte.
- in_data  input  8  message byte, first byte = most significant.
- in_last  input  1  final beat of the message.
- in_empty  input  1  with in_last: beat carries no byte (zero-length message); legal only as first beat.
- blk_valid  output  1  blk_data holds a block.
- blk_ready  input  1  core accepts the block.
- blk_data  output  512  padded block; byte i at bits [511-8i -: 8].
- blk_first  output  1  block is the first of its message.
- blk_last  output  1  block is the final block (holds the length field).

Behaviour:
- Reset (async, active-high):
  - state=LOAD; byte index idx=0; bit count len=0; buffer cleared.
  - blk_valid=0, blk_first=0, blk_last=0, blk_data=0.
  - in_ready is 0 while reset is high.
- States:
  - LOAD: in_ready=1, blk_valid=0.
  - EMIT: in_ready=0, blk_valid=1.
  - EMIT2: second pad-only block pending.
- Beat accept (in_valid and in_ready):
  - Write the byte at buffer[idx]; idx += 1; len += 8 (mod 2^64).
- Full block, not last: the 64th byte accepted at cycle t gives blk_valid=1 at t+1 in EMIT. On blk_ready the padder returns to LOAD with idx=0 and the buffer zeroed.
- Last byte accepted with resulting idx=n:
  - n ≤ 55: write 0x80 at byte n, zeros to byte 55, len at bytes 56..63. Go to EMIT with blk_last=1.
  - 56 ≤ n ≤ 63: write 0x80 at byte n, zeros to the end. Go to EMIT with blk_last=0, then EMIT2: all-zero block with len in bytes 56..63, blk_last=1.
  - n = 64: EMIT the data block (blk_last=0), then EMIT2: 0x80 at byte 0, zeros, len, blk_last=1.
  - in_empty with in_last: 0x80 at byte 0, len=0. EMIT with blk_first=blk_last=1.
- len used in the length field includes the final byte.
- Latency: last-beat accept at t gives blk_valid at t+1. EMIT to EMIT2 takes 1 cycle after the handshake.
- Handshake rules:
  - blk_data, blk_first and blk_last hold stable while blk_valid && !blk_ready.
  - blk_valid never drops without a handshake.
  - in_ready stays 0 in EMIT and EMIT2, so no byte is lost under backpressure.
- blk_first: 1 on the first block after reset or after a blk_last handshake; 0 otherwise.
- After the final handshake: len=0, idx=0, state=LOAD.
- Reset mid-message or mid-EMIT: the block is discarded and the next message starts clean.
- Illegal input: in_empty without in_last, or in_empty on a non-first beat, is ignored (treated as in_empty=0).

Optional Feature:
- Macro: SHA_PAD_STATS_EN.
- Defined: adds output blk_idx[31:0], the zero-based index of the current block within its message. It resets to 0, increments on each blk handshake, clears after the blk_last handshake, and is stable under backpressure.
- Undefined: the port and counter are absent.

Decomposition:
- sha256_pkg holds:
  - BLOCK_W=512, WORD_W=32, LEN_W=64.
  - PAD_BYTE=8'h80, LEN_OFFSET=56 (byte offset of the length field).
  - Enum pad_state_t {LOAD, EMIT, EMIT2}.
- One sub-module, sha_pad_tail (combinational). Inputs: buffer, n, len. Outputs: first padded block, second block, and a needs_two flag.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) → one block 0x61626380, zeros, final word 0x00000018; blk_first=blk_last=1.
- 55 bytes 0x00..0x36 → one block, 0x80 at byte 55, length 0x1B8, blk_last=1.
- 56 bytes → block 1 is the data plus 0x80 at byte 56 (blk_first=1, blk_last=0); block 2 is zeros with length 0x1C0 (blk_last=1).
- 64 bytes 0xAA → block 1 all 0xAA; block 2 is 0x80 at byte 0 with length 0x200. 65 bytes → 2 blocks, length 0x208.
- Zero-length (in_last=in_empty=1) → 0x80000000 followed by zeros, length 0.
- Backpressure and reset:
  - Hold blk_ready=0 for 5 cycles: blk_data is constant and in_ready=0 throughout.
  - Assert reset after 10 bytes, then send "abc": the output matches the "abc" case.
